// File: rtl/tape_pkg.sv
// Shared tape-interface definitions.
// Holds the ROM-loader T-state timings, standard pilot counts, the
// T-state -> clock-cycle conversion and the block state encoding, which
// the receive-side tape blocks decode with the same values.
package tape_pkg;

  localparam int TMR_W = 32;

  // Half-period lengths in Spectrum T-states
  localparam int unsigned T_PILOT = 2168;
  localparam int unsigned T_SYNC1 = 667;
  localparam int unsigned T_SYNC2 = 735;
  localparam int unsigned T_BIT0  = 855;
  localparam int unsigned T_BIT1  = 1710;

  // Pilot half-period counts, selected by bit 7 of the flag byte
  localparam int unsigned PILOT_HDR_CNT  = 8063;
  localparam int unsigned PILOT_DATA_CNT = 3223;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PILOT = 3'd1;
  localparam logic [2:0] ST_SYNC1 = 3'd2;
  localparam logic [2:0] ST_SYNC2 = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_PAUSE = 3'd5;

  // T-states -> clk cycles, truncated. The product needs 64 bits
  // (e.g. 2168 * 27 MHz); the result always fits 32.
  function automatic logic [TMR_W-1:0] tstate_to_cyc(input int unsigned t,
                                                     input int unsigned clk_hz,
                                                     input int unsigned ts_hz);
    logic [63:0] prod;
    prod = 64'(t) * 64'(clk_hz);
    return TMR_W'(prod / 64'(ts_hz));
  endfunction

endpackage

// File: rtl/tape_halfperiod_timer.sv
// Half-period countdown timer.
// load  : start a new interval of len cycles (takes priority over stop)
// len   : interval length in clk cycles, >= 1
// stop  : halt the timer; expire stays low until the next load
// expire: high on the last cycle of the interval, i.e. len cycles after
//         the load edge, so the owner's next edge lands exactly on time
module tape_halfperiod_timer
  import tape_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [TMR_W-1:0] len,
  input  logic             stop,
  output logic             expire
);

  logic [TMR_W-1:0] cnt;
  logic             run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= len - TMR_W'(1);
      run <= 1'b1;
    end else if (stop) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (run && cnt != '0) begin
      cnt <= cnt - TMR_W'(1);
    end
  end

  assign expire = run && (cnt == '0);

endmodule

// File: rtl/tape_encoder.sv
// ZX Spectrum tape signal generator (save/playback side).
// Per block: pilot tone, sync1, sync2, data bits MSB-first, silent pause.
// Ports:
//   clk, reset_n      : clock, async active-low reset
//   s_data/s_valid/s_last/s_ready : byte stream, s_last marks block end
//   aud               : registered square-wave output
//   busy              : high outside IDLE
//   underrun          : one-cycle pulse when a mid-block byte is missing
module tape_encoder
  import tape_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 27000000,
  parameter int unsigned TSTATE_HZ  = 3500000,
  parameter int unsigned PILOT_HDR  = PILOT_HDR_CNT,
  parameter int unsigned PILOT_DATA = PILOT_DATA_CNT,
  parameter int unsigned PAUSE_MS   = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       aud,
  output logic       busy,
  output logic       underrun
);

  localparam logic [TMR_W-1:0] LEN_PILOT = tstate_to_cyc(T_PILOT, CLK_FREQ, TSTATE_HZ);
  localparam logic [TMR_W-1:0] LEN_SYNC1 = tstate_to_cyc(T_SYNC1, CLK_FREQ, TSTATE_HZ);
  localparam logic [TMR_W-1:0] LEN_SYNC2 = tstate_to_cyc(T_SYNC2, CLK_FREQ, TSTATE_HZ);
  localparam logic [TMR_W-1:0] LEN_BIT0  = tstate_to_cyc(T_BIT0, CLK_FREQ, TSTATE_HZ);
  localparam logic [TMR_W-1:0] LEN_BIT1  = tstate_to_cyc(T_BIT1, CLK_FREQ, TSTATE_HZ);
  localparam logic [TMR_W-1:0] PAUSE_CYC = TMR_W'((CLK_FREQ / 1000) * PAUSE_MS);

  logic [2:0]       state;
  logic [TMR_W-1:0] pilot_left;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic             half;       // 0: first half of current bit, 1: second
  logic             last_flag;

  logic             expire, tmr_load, tmr_stop;
  logic [TMR_W-1:0] tmr_len;
  logic             byte_end;

  tape_halfperiod_timer u_tmr (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (tmr_load),
    .len    (tmr_len),
    .stop   (tmr_stop),
    .expire (expire)
  );

  // Byte loads coincide with the expiry that ends the previous half-period,
  // so the next length is already known from the incoming byte's bit 7 and
  // no gap cycle appears. The SYNC2 expiry is the entry load of DATA.
  assign byte_end = (state == ST_DATA) && expire && half && (bit_idx == 3'd7);
  assign s_ready  = ((state == ST_SYNC2) && expire) || (byte_end && !last_flag);
  assign underrun = byte_end && !last_flag && !s_valid;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    tmr_load = 1'b0;
    tmr_stop = 1'b0;
    tmr_len  = LEN_PILOT;
    case (state)
      ST_IDLE:  tmr_load = s_valid;
      ST_PILOT: begin
        tmr_load = expire;
        if (pilot_left == TMR_W'(1)) tmr_len = LEN_SYNC1;
      end
      ST_SYNC1: begin
        tmr_load = expire;
        tmr_len  = LEN_SYNC2;
      end
      ST_SYNC2: begin
        tmr_load = expire;
        tmr_len  = s_data[7] ? LEN_BIT1 : LEN_BIT0;
      end
      ST_DATA: begin
        tmr_load = expire;
        if (!half)                      tmr_len = shift[7] ? LEN_BIT1 : LEN_BIT0;
        else if (bit_idx != 3'd7)       tmr_len = shift[6] ? LEN_BIT1 : LEN_BIT0;
        else if (last_flag || !s_valid) tmr_len = PAUSE_CYC;
        else                            tmr_len = s_data[7] ? LEN_BIT1 : LEN_BIT0;
      end
      ST_PAUSE: tmr_stop = expire;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      aud        <= 1'b0;
      pilot_left <= '0;
      shift      <= '0;
      bit_idx    <= '0;
      half       <= 1'b0;
      last_flag  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (s_valid) begin
          // Flag byte is only peeked here; it is accepted on SYNC2 expiry.
          aud        <= ~aud;
          pilot_left <= s_data[7] ? TMR_W'(PILOT_DATA) : TMR_W'(PILOT_HDR);
          state      <= ST_PILOT;
        end
        ST_PILOT: if (expire) begin
          // N pilot half-periods; the N-th expiry toggles into SYNC1.
          aud        <= ~aud;
          pilot_left <= pilot_left - TMR_W'(1);
          if (pilot_left == TMR_W'(1)) state <= ST_SYNC1;
        end
        ST_SYNC1: if (expire) begin
          aud   <= ~aud;
          state <= ST_SYNC2;
        end
        ST_SYNC2: if (expire) begin
          aud       <= ~aud;
          shift     <= s_data;
          last_flag <= s_last;
          bit_idx   <= '0;
          half      <= 1'b0;
          state     <= ST_DATA;
        end
        ST_DATA: if (expire) begin
          if (!half) begin
            half <= 1'b1;
            aud  <= ~aud;
          end else begin
            half <= 1'b0;
            if (bit_idx != 3'd7) begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {shift[6:0], 1'b0};
              aud     <= ~aud;
            end else if (last_flag || !s_valid) begin
              aud   <= 1'b0;
              state <= ST_PAUSE;
            end else begin
              aud       <= ~aud;
              shift     <= s_data;
              last_flag <= s_last;
              bit_idx   <= '0;
            end
          end
        end
        ST_PAUSE: if (expire) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tape_encoder.sv
module tb_tape_encoder;
  import tape_pkg::*;

  localparam int unsigned CLK_F = 350000;
  localparam int unsigned TS_F  = 3500000;
  localparam int unsigned PH    = 6;
  localparam int unsigned PD    = 3;
  localparam int unsigned PMS   = 2;
  localparam int unsigned PAUSE = (CLK_F / 1000) * PMS;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0, s_last = 1'b0;
  logic       s_ready, aud, busy, underrun;

  tape_encoder #(.CLK_FREQ(CLK_F), .TSTATE_HZ(TS_F), .PILOT_HDR(PH),
                 .PILOT_DATA(PD), .PAUSE_MS(PMS)) dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .aud(aud), .busy(busy),
    .underrun(underrun));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; bit last; bit hole; } src_t;
  typedef struct { int unsigned t; int unsigned hz; int unsigned want; } conv_t;

  src_t src_q[$];
  bit   exp_aud[$], exp_busy[$], exp_rdy[$], exp_und[$];
  int   exp_hs, hs_cnt;
  bit   hs;
  int   total, passed;
  int   err_n[4], err_idx[4];
  logic err_got[4];
  string sig_name[4] = '{"underrun", "s_ready", "busy", "aud"};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  // Expected cycle counts straight from the T-state rule.
  function automatic int unsigned cyc(input int unsigned t);
    return int'((longint'(t) * longint'(CLK_F)) / longint'(TS_F));
  endfunction

  task automatic push_smp(input bit a, input bit b);
    exp_aud.push_back(a); exp_busy.push_back(b);
    exp_rdy.push_back(1'b0); exp_und.push_back(1'b0);
  endtask

  task automatic push_seg(input bit lvl, input int unsigned n);
    repeat (n) push_smp(lvl, 1'b1);
  endtask

  // Waveform model: one idle sample (flag peeked), then alternating-level
  // segments starting high, then the silent pause.
  task automatic add_block(input src_t blk[$]);
    bit lvl = 1'b1;
    foreach (blk[i]) src_q.push_back(blk[i]);
    push_smp(1'b0, 1'b0);
    repeat (blk[0].data[7] ? PD : PH) begin push_seg(lvl, cyc(2168)); lvl = !lvl; end
    push_seg(lvl, cyc(667)); lvl = !lvl;
    push_seg(lvl, cyc(735)); lvl = !lvl;
    for (int j = 0; j < blk.size(); j++) begin
      exp_rdy[exp_rdy.size()-1] = 1'b1;
      if (blk[j].hole) begin exp_und[exp_und.size()-1] = 1'b1; break; end
      exp_hs++;
      for (int b = 7; b >= 0; b--)
        repeat (2) begin push_seg(lvl, blk[j].data[b] ? cyc(1710) : cyc(855)); lvl = !lvl; end
      if (blk[j].last) break;
    end
    push_seg(1'b0, PAUSE);
  endtask

  task automatic drive_src();
    if (src_q.size() > 0 && !src_q[0].hole) begin
      s_valid = 1'b1; s_data = src_q[0].data; s_last = src_q[0].last;
    end else begin
      s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    end
  endtask

  // Steps one cycle per expected sample; limit < 0 runs the whole queue.
  task automatic check_run(input string name, input int limit);
    int idx = 0;
    logic [3:0] got;
    bit [3:0] want;
    for (int s = 0; s < 4; s++) begin err_n[s] = 0; err_idx[s] = 0; err_got[s] = 1'b0; end
    hs_cnt = 0;
    while (exp_aud.size() > 0 && (limit < 0 || idx < limit)) begin
      @(posedge clk); #1;
      if (hs && src_q.size() > 0) begin void'(src_q.pop_front()); hs_cnt++; end
      drive_src();
      #1;
      hs = s_valid && s_ready;
      got  = {aud, busy, s_ready, underrun};
      want = {exp_aud.pop_front(), exp_busy.pop_front(), exp_rdy.pop_front(), exp_und.pop_front()};
      for (int s = 0; s < 4; s++)
        if (got[s] !== want[s]) begin
          if (err_n[s] == 0) begin err_idx[s] = idx; err_got[s] = got[s]; end
          err_n[s]++;
        end
      idx++;
    end
    for (int s = 0; s < 4; s++) begin
      total++;
      if (err_n[s] == 0) passed++;
      else $display("FAIL %s.%s: %0d bad cycles, first at sample %0d got %b want %b",
                    name, sig_name[s], err_n[s], err_idx[s], err_got[s], !err_got[s]);
    end
    if (limit < 0) begin
      chk({name, ".accepts"}, hs_cnt, exp_hs);
      exp_hs = 0;
    end
  endtask

  initial begin
    conv_t tbl[10];
    src_t b[$], b2[$];
    total = 0; passed = 0; exp_hs = 0; hs = 1'b0;

    tbl = '{'{2168, 27000000, 16724}, '{667, 27000000, 5145}, '{735, 27000000, 5670},
            '{855, 27000000, 6595}, '{1710, 27000000, 13191}, '{2168, 3500000, 2168},
            '{667, 3500000, 667}, '{735, 3500000, 735}, '{855, 3500000, 855},
            '{1710, 3500000, 1710}};
    for (int i = 0; i < 10; i++)
      chk($sformatf("conv[%0d]", i), tstate_to_cyc(tbl[i].t, tbl[i].hz, 3500000), tbl[i].want);

    repeat (3) @(posedge clk);
    #1 chk("reset_outs", {28'h0, aud, busy, s_ready, underrun}, 32'h0);
    @(negedge clk) reset_n = 1'b1;

    // Header block, one byte
    b = {}; b.push_back('{8'h00, 1'b1, 1'b0});
    add_block(b); check_run("hdr", -1);

    // Data block 0xFF, 0xA5
    b = {}; b.push_back('{8'hFF, 1'b0, 1'b0}); b.push_back('{8'hA5, 1'b1, 1'b0});
    add_block(b); check_run("data", -1);

    // Underrun: second byte withheld
    b = {}; b.push_back('{8'h00, 1'b0, 1'b0}); b.push_back('{8'h33, 1'b0, 1'b1});
    b.push_back('{8'h44, 1'b1, 1'b0});
    add_block(b); check_run("underrun", -1);
    chk("underrun_left", src_q.size(), 2);
    src_q.delete();

    // Back-to-back: second flag already valid during the first pause
    b = {}; b.push_back('{8'h00, 1'b1, 1'b0});
    b2 = {}; b2.push_back('{8'h90, 1'b0, 1'b0}); b2.push_back('{8'h0F, 1'b1, 1'b0});
    add_block(b); add_block(b2); check_run("b2b", -1);

    // Async reset mid-pilot, then a clean restart
    b = {}; b.push_back('{8'h12, 1'b1, 1'b0});
    add_block(b); check_run("rst_pre", 300);
    @(posedge clk); #3 reset_n = 1'b0; #1;
    chk("rst_async", {29'h0, aud, busy, s_ready}, 32'h0);
    src_q.delete(); exp_aud.delete(); exp_busy.delete(); exp_rdy.delete(); exp_und.delete();
    exp_hs = 0; hs = 1'b0; drive_src();
    repeat (3) @(posedge clk);
    #1 chk("rst_hold", {29'h0, aud, busy, s_ready}, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    b = {}; b.push_back('{8'h80, 1'b1, 1'b0});
    add_block(b); check_run("rst_restart", -1);

    // Randomized blocks
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 2);
      b = {};
      for (int j = 0; j < n; j++) b.push_back('{8'($urandom), (j == n - 1), 1'b0});
      add_block(b); check_run($sformatf("rnd%0d", r), -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tape_encoder.md
Name: tape_encoder

Overview:
- Generates a ZX Spectrum tape audio signal (square wave on `aud`) from a byte stream. This is the playback/save side of the tape interface.
- Per block: pilot tone, then sync1/sync2 pulses, then data bits MSB-first, then a silence pause.
- Bytes arrive over a valid/ready stream. `s_last` marks the final byte of a block.
- Sits between the save/tape-image source logic and the audio output pin.

Parameters:
- CLK_FREQ, 27000000, system clock frequency in Hz.
- TSTATE_HZ, 3500000, Spectrum T-state rate used for pulse timing.
- PILOT_HDR, 8063, pilot half-periods when flag byte < 0x80.
- PILOT_DATA, 3223, pilot half-periods when flag byte >= 0x80.
- PAUSE_MS, 1000, silence after each block, in ms.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- s_data, input, 8, byte to encode.
- s_valid, input, 1, s_data/s_last valid.
- s_last, input, 1, byte is the last of its block.
- s_ready, output, 1, byte accepted on the cycle where s_valid && s_ready.
- aud, output, 1, tape audio square wave.
- busy, output, 1, high in every state except IDLE.
- underrun, output, 1, one-cycle pulse when the stream starves mid-block.

Behaviour:
- Reset is asynchronous, active-low on reset_n; clock is clk. In reset: aud=0, s_ready=0, busy=0, underrun=0, state=IDLE, all counters 0. Assertion mid-operation aborts immediately with no pause.
- Half-period lengths, in clk cycles, each = T * CLK_FREQ / TSTATE_HZ, computed with integer truncation in 32-bit constants:
  - PILOT: T=2168, default 16724.
  - SYNC1: T=667, default 5145.
  - SYNC2: T=735, default 5670.
  - BIT0: T=855, default 6595.
  - BIT1: T=1710, default 13191.
  - PAUSE_CYC = (CLK_FREQ/1000)*PAUSE_MS.
- Half-period timer: loads length L; aud toggles on the cycle the timer expires, i.e. exactly L cycles after the previous toggle.
- States: IDLE -> PILOT -> SYNC1 -> SYNC2 -> DATA -> PAUSE -> IDLE.
- IDLE:
  - When s_valid=1, peek s_data (the flag byte) without accepting it. Select the pilot count: PILOT_HDR if s_data[7]==0, else PILOT_DATA.
  - On that same cycle, toggle aud (first edge) and go to PILOT.
- PILOT: emits the selected number of pilot half-periods. The count includes the initial toggle interval, so exactly N toggles occur, the last one at the PILOT->SYNC1 boundary.
- SYNC1: one SYNC1 half-period, toggle, go to SYNC2.
- SYNC2: one SYNC2 half-period, toggle, go to DATA.
- DATA, byte load:
  - On entry and after each completed byte, s_ready=1 for that single cycle.
  - Entry from SYNC2: the flag byte is still presented, so s_valid is guaranteed; load shift register and last_flag.
  - Later bytes: if s_valid=0 on the load cycle, underrun pulses 1 cycle and the FSM goes to PAUSE. The byte is not accepted.
- DATA, bit timing: each bit = two half-periods of BIT0/BIT1 length, chosen by shift[7]. Toggle after each half, shift left after the second half. 8 bits per byte.
- DATA, end of byte: after bit 7, if last_flag=1 go to PAUSE, else load the next byte.
- PAUSE: aud forced to 0 on entry and held for PAUSE_CYC cycles, then IDLE.
- s_valid in PAUSE is ignored; s_ready stays 0 outside DATA load cycles.
- busy=1 in every non-IDLE state.
- aud is registered directly; no glitches.
- Simultaneous events: expiry and state change occur on the same cycle. The next length is loaded on that cycle, so there are no idle gap cycles between half-periods.

Decomposition:
- Shared package tape_pkg holds:
  - T-state constants: 2168, 667, 735, 855, 1710.
  - Pilot counts 8063 and 3223.
  - A function converting T-states to cycles.
  - The state encoding, which tape_pkg also shares with receive-side tape blocks.
- One natural sub-module, tape_halfperiod_timer: 32-bit load/countdown with expire pulse.

Test Plan:
- Header block, 1 byte: s_data=0x00, s_last=1, default params.
  - 8063 pilot toggles spaced 16724 cycles, then 5145 and 5670.
  - Then 16 halves of 6595.
  - Then aud=0 for 27,000,000 cycles; busy falls; s_ready pulses exactly once.
- Data block, bytes 0xFF,0xA5 (last on 0xA5):
  - 3223 pilot toggles.
  - 0xFF gives 16 halves of 13191.
  - 0xA5 gives half-pairs 1,0,1,0,0,1,0,1 (13191/6595).
  - Two accept handshakes total.
- Underrun: 3-byte block with s_valid dropped before byte 2.
  - underrun=1 for exactly one cycle after byte 1's last half; byte 2 not accepted.
  - Enters PAUSE with aud=0.
- Reset mid-PILOT: pull reset_n low asynchronously for 3 cycles.
  - aud=0, busy=0, s_ready=0 immediately; IDLE after release; restarts cleanly with new flag byte.
- Back-to-back blocks: second block valid during PAUSE.
  - Not accepted until PAUSE ends; its pilot starts on the first IDLE cycle.
- Scaled params CLK_FREQ=3500000: half-periods equal raw T-states (2168, 667, 735, 855, 1710) exactly.
